// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the fetch / load-store memory port arbiter.
// Imported by the round-robin picker and the arbiter top.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int LAT_DEFAULT = 2;

    // Wide enough for LAT-1 with LAT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin choice between the fetch (A) and load/store (B) requesters.
// A tie goes to whichever port was not granted last.
module rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_sel
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
        grant_valid = req_a | req_b;
        grant_sel   = SEL_A;
        if (req_a && req_b) begin
            grant_sel = (last_grant == SEL_A) ? SEL_B : SEL_A;
        end else if (req_b) begin
            grant_sel = SEL_B;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (A) and load/store (B):
// round-robin grant, LAT-cycle access, captured read data and a one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N   = 32,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic [N-1:0] addr_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [N-1:0] addr_b,
    input  logic         we_b,
    input  logic [N-1:0] wdata_b,
    output logic         ack_b,
    output logic [N-1:0] rdata,
    output logic         mem_en,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         sel,
    output logic         busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic             grant_sel;

    rr_pick u_rr_pick (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Steering follows the held grant; requesters keep address and data stable until ack.
    assign mem_addr  = sel ? addr_b : addr_a;
    assign mem_wdata = wdata_b;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= SEL_A;
            last_grant <= SEL_B;
            cnt        <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        sel        <= grant_sel;
                        last_grant <= grant_sel;
                        cnt        <= CNT_LOAD;
                        mem_en     <= 1'b1;
                        mem_we     <= we_b & (grant_sel == SEL_B);
                        busy       <= 1'b1;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Counter reaching zero marks the last access cycle, when mem_rdata is valid.
                    if (cnt == '0) begin
                        rdata  <= mem_rdata;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        ack_a  <= (sel == SEL_A);
                        ack_b  <= (sel == SEL_B);
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=2 and LAT=1), a bench-side memory,
// a transaction-schedule model checked every cycle, and directed literal checks.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N    = 32;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         req_a_v     [2];
    logic         req_b_v     [2];
    logic         we_b_v      [2];
    logic [N-1:0] addr_a_v    [2];
    logic [N-1:0] addr_b_v    [2];
    logic [N-1:0] wdata_b_v   [2];
    logic [N-1:0] mem_rdata_v [2];
    logic         ack_a_v     [2];
    logic         ack_b_v     [2];
    logic         mem_en_v    [2];
    logic         mem_we_v    [2];
    logic         sel_v       [2];
    logic         busy_v      [2];
    logic [N-1:0] rdata_v     [2];
    logic [N-1:0] mem_addr_v  [2];
    logic [N-1:0] mem_wdata_v [2];

    mem_port_arbiter #(.N(N), .LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst),
        .req_a(req_a_v[0]), .addr_a(addr_a_v[0]), .ack_a(ack_a_v[0]),
        .req_b(req_b_v[0]), .addr_b(addr_b_v[0]), .we_b(we_b_v[0]),
        .wdata_b(wdata_b_v[0]), .ack_b(ack_b_v[0]), .rdata(rdata_v[0]),
        .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
        .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]),
        .sel(sel_v[0]), .busy(busy_v[0])
    );

    mem_port_arbiter #(.N(N), .LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .req_a(req_a_v[1]), .addr_a(addr_a_v[1]), .ack_a(ack_a_v[1]),
        .req_b(req_b_v[1]), .addr_b(addr_b_v[1]), .we_b(we_b_v[1]),
        .wdata_b(wdata_b_v[1]), .ack_b(ack_b_v[1]), .rdata(rdata_v[1]),
        .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
        .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]),
        .sel(sel_v[1]), .busy(busy_v[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [N-1:0] init_word(input int a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        if (a == 32'h104) return 32'hCAFE_F00D;
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    task automatic check(input string name, input int inst, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[dut%0d] cycle %0d: got %h, want %h", name, inst, cyc, act, exp);
        end
    endtask

    // Bench memory: read data appears only on the LAT-th consecutive enabled cycle.
    logic [N-1:0] phys [2][1024];
    int           en_run [2];

    assign mem_rdata_v[0] = (mem_en_v[0] && en_run[0] == LAT0 - 1) ? phys[0][mem_addr_v[0][11:2]] : 32'h0BAD_0BAD;
    assign mem_rdata_v[1] = (mem_en_v[1] && en_run[1] == LAT1 - 1) ? phys[1][mem_addr_v[1][11:2]] : 32'h0BAD_0BAD;

    initial begin
        for (int i = 0; i < 2; i++) begin
            en_run[i] <= 0;
            for (int w = 0; w < 1024; w++) phys[i][w] <= init_word(w * 4);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            en_run[i] <= mem_en_v[i] ? en_run[i] + 1 : 0;
            if (mem_en_v[i] && mem_we_v[i] && en_run[i] == lat_of(i) - 1)
                phys[i][mem_addr_v[i][11:2]] <= mem_wdata_v[i];
        end
    end

    // Model: a grant at edge g occupies cycles g+1..g+LAT (access) and g+LAT+1 (ack);
    // the next request can be taken at edge g+LAT+2.
    bit           m_valid [2];
    bit           m_active[2];
    int           m_g     [2];
    logic         m_sel   [2];
    logic         m_we    [2];
    logic         m_last  [2];
    logic [N-1:0] m_pend  [2];
    bit           m_pend_known[2];
    logic [N-1:0] m_rd    [2];
    bit           m_rd_known[2];
    logic [N-1:0] exp_mem [2][1024];
    bit           e_ack_a [2];
    bit           e_ack_b [2];
    bit           e_en    [2];
    bit           e_we    [2];
    bit           e_busy  [2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int           lat;
            int           ph;
            logic         s;
            logic [N-1:0] a;
            lat = lat_of(i);
            if (rst) begin
                m_valid[i]    = 1'b1;
                m_active[i]   = 1'b0;
                m_last[i]     = SEL_B;
                m_sel[i]      = SEL_A;
                m_we[i]       = 1'b0;
                m_rd[i]       = '0;
                m_rd_known[i] = 1'b1;
            end else if (m_valid[i]) begin
                if (m_active[i] && cyc >= m_g[i] + lat + 2) m_active[i] = 1'b0;
                if (!m_active[i] && (req_a_v[i] || req_b_v[i])) begin
                    if (req_a_v[i] && req_b_v[i]) s = ~m_last[i];
                    else s = req_b_v[i];
                    m_last[i]   = s;
                    m_sel[i]    = s;
                    m_active[i] = 1'b1;
                    m_g[i]      = cyc;
                    m_we[i]     = s & we_b_v[i];
                    a = s ? addr_b_v[i] : addr_a_v[i];
                    if (m_we[i]) begin
                        exp_mem[i][a[11:2]] = wdata_b_v[i];
                        m_pend_known[i] = 1'b0;
                    end else begin
                        m_pend[i] = exp_mem[i][a[11:2]];
                        m_pend_known[i] = 1'b1;
                    end
                end
            end
            e_ack_a[i] = 1'b0;
            e_ack_b[i] = 1'b0;
            e_en[i]    = 1'b0;
            e_we[i]    = 1'b0;
            e_busy[i]  = 1'b0;
            if (!rst && m_valid[i] && m_active[i]) begin
                ph = cyc + 1 - m_g[i];
                if (ph <= lat) begin
                    e_en[i]   = 1'b1;
                    e_we[i]   = m_we[i];
                    e_busy[i] = 1'b1;
                end else if (ph == lat + 1) begin
                    e_busy[i]     = 1'b1;
                    e_ack_a[i]    = ~m_sel[i];
                    e_ack_b[i]    = m_sel[i];
                    m_rd[i]       = m_pend[i];
                    m_rd_known[i] = m_pend_known[i];
                end
            end
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 1024; w++) exp_mem[i][w] = init_word(w * 4);
            m_valid[i] = 1'b0;
            m_active[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic compare_step();
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                check("ack_a", i, 32'(ack_a_v[i]), 32'(e_ack_a[i]));
                check("ack_b", i, 32'(ack_b_v[i]), 32'(e_ack_b[i]));
                check("mem_en", i, 32'(mem_en_v[i]), 32'(e_en[i]));
                check("mem_we", i, 32'(mem_we_v[i]), 32'(e_we[i]));
                check("busy", i, 32'(busy_v[i]), 32'(e_busy[i]));
                check("sel", i, 32'(sel_v[i]), 32'(m_sel[i]));
                check("mem_addr", i, mem_addr_v[i], m_sel[i] ? addr_b_v[i] : addr_a_v[i]);
                check("mem_wdata", i, mem_wdata_v[i], wdata_b_v[i]);
                if (m_rd_known[i]) check("rdata", i, rdata_v[i], m_rd[i]);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            compare_step();
        end
    end

    // One transaction on instance i; started in an idle cycle, ends on the ack negedge with req dropped.
    task automatic txn(input int i, input bit port_b, input logic [N-1:0] addr, input bit we,
                       input logic [N-1:0] wdata, input bit chk_rd, input logic [N-1:0] exp_rd);
        int n, en_n, we_n, other;
        bit seen, sel_ok, addr_ok;
        n = 0; en_n = 0; we_n = 0; other = 0; seen = 0; sel_ok = 1; addr_ok = 1;
        @(negedge clk);
        if (port_b) begin
            addr_b_v[i] = addr; we_b_v[i] = we; wdata_b_v[i] = wdata; req_b_v[i] = 1'b1;
        end else begin
            addr_a_v[i] = addr; req_a_v[i] = 1'b1;
        end
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_en_v[i]) begin
                en_n++;
                if (mem_addr_v[i] !== addr) addr_ok = 0;
            end
            if (mem_we_v[i]) we_n++;
            if (busy_v[i] && sel_v[i] !== port_b) sel_ok = 0;
            if ((port_b ? ack_a_v[i] : ack_b_v[i]) === 1'b1) other++;
            if ((port_b ? ack_b_v[i] : ack_a_v[i]) === 1'b1) begin
                seen = 1;
                req_a_v[i] = 1'b0;
                req_b_v[i] = 1'b0;
                we_b_v[i]  = 1'b0;
            end
        end
        check("txn_ack_latency", i, 32'(seen ? n : -1), 32'(lat_of(i) + 1));
        check("txn_en_cycles", i, 32'(en_n), 32'(lat_of(i)));
        check("txn_we_cycles", i, 32'(we_n), we ? 32'(lat_of(i)) : 32'd0);
        check("txn_addr_steer", i, 32'(addr_ok), 32'd1);
        check("txn_sel_held", i, 32'(sel_ok), 32'd1);
        check("txn_other_ack", i, 32'(other), 32'd0);
        if (chk_rd) check("txn_rdata", i, rdata_v[i], exp_rd);
        req_a_v[i] = 1'b0;
        req_b_v[i] = 1'b0;
    endtask

    initial begin
        int        n, acks, dbl, en_n;
        bit        seen;
        logic [3:0] order;
        for (int i = 0; i < 2; i++) begin
            req_a_v[i] = 0; req_b_v[i] = 0; we_b_v[i] = 0;
            addr_a_v[i] = '0; addr_b_v[i] = '0; wdata_b_v[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", 0, rdata_v[0], 32'h0);
        check("reset_busy", 0, 32'(busy_v[0]), 32'd0);
        check("reset_sel", 1, 32'(sel_v[1]), 32'd0);
        rst = 1'b0;

        // Single read on A, then store on B and read-back on B.
        txn(0, 1'b0, 32'h100, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h200, 1'b1, 32'h1234_5678, 1'b0, '0);
        txn(0, 1'b1, 32'h200, 1'b0, '0, 1'b1, 32'h1234_5678);

        // Contention out of reset: both held for four transactions.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        addr_a_v[0] = 32'h300; addr_b_v[0] = 32'h040; we_b_v[0] = 1'b0;
        req_a_v[0] = 1'b1; req_b_v[0] = 1'b1;
        acks = 0; dbl = 0; order = '0; n = 0;
        while (acks < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (ack_a_v[0] && ack_b_v[0]) dbl++;
            if (ack_a_v[0] || ack_b_v[0]) begin
                order[acks] = ack_b_v[0];
                acks++;
            end
            if (acks == 4) begin
                req_a_v[0] = 1'b0; req_b_v[0] = 1'b0;
            end
        end
        req_a_v[0] = 1'b0; req_b_v[0] = 1'b0;
        check("contend_acks", 0, 32'(acks), 32'd4);
        check("contend_order", 0, 32'(order), 32'b1010);
        check("contend_double_ack", 0, 32'(dbl), 32'd0);

        // req_b dropped one cycle into ACCESS.
        @(negedge clk);
        @(negedge clk);
        addr_b_v[0] = 32'h200; req_b_v[0] = 1'b1;
        @(negedge clk);
        req_b_v[0] = 1'b0;
        en_n = mem_en_v[0] ? 1 : 0;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_en_v[0]) en_n++;
            if (ack_b_v[0]) seen = 1;
        end
        check("drop_ack_b", 0, 32'(seen), 32'd1);
        check("drop_en_cycles", 0, 32'(en_n), 32'd2);
        check("drop_rdata", 0, rdata_v[0], 32'h1234_5678);

        // Reset during a B access.
        @(negedge clk);
        @(negedge clk);
        addr_b_v[0] = 32'h040; req_b_v[0] = 1'b1;
        @(negedge clk);
        check("rst_pre_en", 0, 32'(mem_en_v[0]), 32'd1);
        rst = 1'b1; req_b_v[0] = 1'b0;
        @(negedge clk);
        check("rst_mem_en", 0, 32'(mem_en_v[0]), 32'd0);
        check("rst_busy", 0, 32'(busy_v[0]), 32'd0);
        check("rst_sel", 0, 32'(sel_v[0]), 32'd0);
        check("rst_acks", 0, 32'({ack_a_v[0], ack_b_v[0]}), 32'd0);

        // Tie granted A, reset mid-access, tie again must go to A.
        rst = 1'b0;
        addr_a_v[0] = 32'h100; req_a_v[0] = 1'b1; req_b_v[0] = 1'b1;
        @(negedge clk);
        check("tie1_sel", 0, 32'(sel_v[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("tie2_sel", 0, 32'(sel_v[0]), 32'd0);
        check("tie2_en", 0, 32'(mem_en_v[0]), 32'd1);
        req_a_v[0] = 1'b0; req_b_v[0] = 1'b0;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (ack_a_v[0]) seen = 1;
        end
        check("tie2_ack_a", 0, 32'(seen), 32'd1);

        // LAT=1 instance.
        txn(1, 1'b0, 32'h104, 1'b0, '0, 1'b1, 32'hCAFE_F00D);
        txn(1, 1'b1, 32'h080, 1'b1, 32'h5555_AAAA, 1'b0, '0);
        txn(1, 1'b1, 32'h080, 1'b0, '0, 1'b1, 32'h5555_AAAA);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
